// File: rtl/seg_pkg.sv
// seg_pkg: segment encodings and bus bit positions shared by the scan driver and hex decoder
package seg_pkg;
  localparam logic [8:0] SEG_OFF = 9'h100;
  localparam int S = 8;
  localparam int P = 7;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble plus decimal point to PGFEDCBA
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);
  always_comb begin
    seg = {1'b0, HEX_SEG[nibble]};
    seg[P] = dp;
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed DIGITS-digit 7-segment driver with frame-synchronous load
// Optional SEG_BLINK_EN adds a per-digit blink input toggling every 256 frames.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int SLOT_CYCLES = 12000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic                lz_en,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]   blink,
`endif
  output logic                busy,
  output logic [8:0]          seg,
  output logic [DIGITS-1:0]   dig_sel
);
  localparam int CW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_value, sh_value;
  logic [DIGITS-1:0]   pend_dp, sh_dp, zero_hi;
  logic                pend_lz, sh_lz;
  logic                wrap, frame, dead, lz_off, blink_off;
  logic [3:0]          nibble;
  logic [7:0]          dec;
  logic [8:0]          seg_d;
  assign wrap  = cnt == CW'(SLOT_CYCLES - 1);
  assign frame = wrap && idx == IW'(DIGITS - 1);
  assign dead  = cnt < CW'(DEAD_CYCLES);
  assign nibble = sh_value[4*idx +: 4];
  // zero_hi[i]: nibble i and every more-significant nibble are zero
  always_comb begin
    zero_hi = '0;
    for (int i = 0; i < DIGITS; i++) zero_hi[i] = (sh_value >> (4 * i)) == '0;
  end
  assign lz_off = sh_lz && idx != '0 && zero_hi[idx];
  seg_hex_decode u_dec (
    .nibble(nibble),
    .dp    (sh_dp[idx]),
    .seg   (dec)
  );
  always_comb begin
    seg_d = {1'b0, blink_off ? 8'h00 : lz_off ? {dec[P], 7'h00} : dec};
    seg_d[S] = 1'b0;
    if (dead) seg_d = SEG_OFF;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_lz    <= 1'b0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      seg        <= SEG_OFF;
      dig_sel    <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= frame ? '0 : idx + 1'b1;
      if (load) {pend_value, pend_dp, pend_lz} <= {value, dp, lz_en};
      if (frame && busy) {sh_value, sh_dp, sh_lz} <= {pend_value, pend_dp, pend_lz};
      busy    <= load || (busy && !frame);
      seg     <= seg_d;
      dig_sel <= dead ? '0 : DIGITS'(1) << idx;
    end
  end
`ifdef SEG_BLINK_EN
  logic [DIGITS-1:0] pend_blink, sh_blink;
  logic [7:0]        frame_cnt;
  logic              phase;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_blink <= '0;
      sh_blink   <= '0;
      frame_cnt  <= '0;
      phase      <= 1'b0;
    end else begin
      if (load) pend_blink <= blink;
      if (frame && busy) sh_blink <= pend_blink;
      if (frame) frame_cnt <= frame_cnt + 8'd1;
      if (frame && frame_cnt == 8'hFF) phase <= ~phase;
    end
  end
  assign blink_off = phase && sh_blink[idx];
`else
  assign blink_off = 1'b0;
`endif
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for 2-digit and 4-digit scan driver instances
module tb_seg_scan_driver;
  logic        clk = 0, rst_n = 0, load = 0, lz_en = 0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        busy2, busy4;
  logic [8:0]  seg2, seg4;
  logic [1:0]  sel2;
  logic [3:0]  sel4;
  always #5 clk = ~clk;
  seg_scan_driver #(.DIGITS(2), .SLOT_CYCLES(8), .DEAD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value[7:0]), .dp(dp[1:0]), .lz_en(lz_en),
`ifdef SEG_BLINK_EN
    .blink(2'b00),
`endif
    .busy(busy2), .seg(seg2), .dig_sel(sel2)
  );
  seg_scan_driver #(.DIGITS(4), .SLOT_CYCLES(8), .DEAD_CYCLES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .lz_en(lz_en),
`ifdef SEG_BLINK_EN
    .blink(4'b0000),
`endif
    .busy(busy4), .seg(seg4), .dig_sel(sel4)
  );
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct packed {
    logic [8:0] seg;
    logic [3:0] sel;
    logic       busy;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0, errors = 0, md = 2, k = 0;
  bit          m_busy, m_plz, m_slz;
  logic [15:0] m_pv, m_sv;
  logic [3:0]  m_pdp, m_sdp;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (digits=%0d k=%0d): got %0h expected %0h", tag, md, k, got, exp);
    end
  endtask
  // expected outputs after the coming edge, built from the model's pre-edge state
  function automatic exp_t predict();
    exp_t        e;
    int          c, i;
    logic [15:0] hi;
    c = k % 8;
    i = (k / 8) % md;
    hi = m_sv >> (4 * i);
    e.busy = 1'b0;
    if (c < 2) begin
      e.seg = 9'h100;
      e.sel = 4'h0;
    end else begin
      e.sel = 4'(1 << i);
      e.seg = {1'b0, m_sdp[i], (m_slz && i > 0 && hi == 16'h0) ? 7'h00 : HEX[hi[3:0]]};
    end
    return e;
  endfunction
  task automatic step();
    exp_t e, got;
    bit   bnd;
    if (!rst_n) begin
      e = '{seg: 9'h100, sel: 4'h0, busy: 1'b0};
      {k, m_busy, m_pv, m_sv, m_pdp, m_sdp, m_plz, m_slz} = '0;
    end else begin
      e = predict();
      bnd = (k % 8 == 7) && ((k / 8) % md == md - 1);
      if (bnd && m_busy) {m_sv, m_sdp, m_slz} = {m_pv, m_pdp, m_plz};
      if (load) begin
        m_pv  = md == 2 ? (value & 16'h00FF) : value;
        m_pdp = md == 2 ? (dp & 4'h3) : dp;
        m_plz = lz_en;
      end
      m_busy = load || (m_busy && !bnd);
      e.busy = m_busy;
      k++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = md == 2 ? '{seg: seg2, sel: {2'b00, sel2}, busy: busy2} : '{seg: seg4, sel: sel4, busy: busy4};
    e = sb.pop_front();
    check("seg", 16'(got.seg), 16'(e.seg));
    check("dig_sel", 16'(got.sel), 16'(e.sel));
    check("busy", 16'(got.busy), 16'(e.busy));
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    value = v;
    dp = d;
    lz_en = lz;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  task automatic wait_k(input int p);
    for (int n = 0; n < 64 && (k % (8 * md)) != p; n++) step();
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 80 && m_busy; n++) step();
  endtask
  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    do_load(16'h003A, 4'h0, 1'b0);
    wait_idle();
    repeat (32) step();
    wait_k(4);
    do_load(16'h0012, 4'b0001, 1'b0);
    repeat (40) step();
    wait_k(3);
    do_load(16'h0011, 4'b0000, 1'b0);
    wait_k(10);
    do_load(16'h0022, 4'b0010, 1'b0);
    repeat (40) step();
    wait_k(15);
    do_load(16'h0055, 4'b0011, 1'b0);
    repeat (40) step();
    wait_k(9);
    do_load(16'h0077, 4'b0011, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (40) step();
    md = 4;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    do_load(16'h0050, 4'h0, 1'b1);
    wait_idle();
    repeat (70) step();
    do_load(16'h0050, 4'b0101, 1'b0);
    wait_idle();
    repeat (70) step();
    do_load(16'h0000, 4'b1000, 1'b1);
    wait_idle();
    repeat (40) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
